// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizing, address-width helper and depth legality check.
// Used by sync_fifo and the dual-clock FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 128;

    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_FWFT       = 1'b1
    } rd_mode_e;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam bit DEFAULT_DEPTH_OK = depth_ok(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, status and threshold bundle for sync_fifo.
// master = client driving requests, slave = the FIFO itself.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::DEFAULT_FIFO_DEPTH
);
    import fifo_pkg::*;

    localparam int AW = addr_width(FIFO_DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [AW:0]           almost_full_thresh;
    logic [AW:0]           almost_empty_thresh;
    logic                  err_clr;
    logic [AW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en, almost_full_thresh, almost_empty_thresh, err_clr,
        input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, almost_full_thresh, almost_empty_thresh, err_clr,
        output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: one write port, one read port that is either
// combinational (FWFT) or registered with a resettable output register.
module sync_fifo_mem #(
    parameter int                 DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int                 DEPTH      = fifo_pkg::DEFAULT_FIFO_DEPTH,
    parameter int                 AW         = fifo_pkg::addr_width(DEPTH),
    parameter fifo_pkg::rd_mode_e RD_MODE    = fifo_pkg::RD_REGISTERED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    import fifo_pkg::*;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; only control state needs a known value,
    // and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (RD_MODE == RD_FWFT) begin : g_comb_read
        logic unused_ctrl;
        assign unused_ctrl = rst ^ re;
        assign rdata       = mem[raddr];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rdata_q;
        logic [DATA_WIDTH-1:0] rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (re) begin
                rdata_d = mem[raddr];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, occupancy count
// and sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::DEFAULT_FIFO_DEPTH
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);
    import fifo_pkg::*;

    localparam int AW = addr_width(FIFO_DEPTH);

`ifdef SYNC_FIFO_FWFT_EN
    localparam rd_mode_e RD_MODE = RD_FWFT;
`else
    localparam rd_mode_e RD_MODE = RD_REGISTERED;
`endif

    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: DATA_WIDTH must be at least 1");
    end

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic full, empty;
    logic wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Full/empty come from the extra pointer MSB: equal low bits with differing
    // MSBs means the writer has lapped the reader exactly once.
    always_comb begin
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        wr_accept = bus.wr_en && !full;
        rd_accept = bus.rd_en && !empty;
    end

    // NOTE: every always_comb output gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle set takes priority.
        if (bus.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (bus.rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (AW),
        .RD_MODE    (RD_MODE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.wr_data),
        .re    (rd_accept),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    if (RD_MODE == RD_FWFT) begin : g_fwft_out
        assign bus.rd_valid = !empty;
        assign bus.rd_data  = empty ? '0 : mem_rdata;
    end else begin : g_reg_out
        logic rd_valid_q;
        logic rd_valid_d;

        assign rd_valid_d = rd_accept;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_valid_d;
            end
        end

        assign bus.rd_valid = rd_valid_q;
        assign bus.rd_data  = mem_rdata;
    end

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= bus.almost_full_thresh);
    assign bus.almost_empty = (count_q <= bus.almost_empty_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
